// File: rtl/mips32_rtype_sequencer.sv
// mips32_rtype_sequencer
//   Multi-cycle MIPS32 R-type executor with a private 32x32 register file.
//   Each instruction walks IDLE -> DECODE -> EXECUTE -> WRITEBACK, one cycle
//   per state. The next instruction cannot be accepted until the previous
//   result has been written, so dependent instructions need no forwarding.
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   instr_valid/instr : instruction offer, taken only in IDLE
//   instr_ready, busy : IDLE / non-IDLE indicators
//   wb_valid, wb_rd, wb_data : completion pulse, destination and result
//   illegal           : rejection pulse (bad opcode or unsupported func)
//   dbg_addr/dbg_data : combinational register-file read port
module mips32_rtype_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DECODE  = 2'd1;
  localparam logic [1:0] S_EXECUTE = 2'd2;
  localparam logic [1:0] S_WB      = 2'd3;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  logic [1:0]  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [4:0]  rd_q, rd_d;
  logic [5:0]  func_q, func_d;
  logic        ill_q, ill_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] rf_q [32];

  logic [31:0] alu_res;
  logic        func_ok;
  logic        rf_we;

  always_comb begin
    func_ok = 1'b0;
    case (instr_q[5:0])
      F_SLL, F_SRL, F_ADD, F_ADDU, F_SUB, F_SUBU,
      F_AND, F_OR, F_NOR, F_SLT, F_SLTU: func_ok = 1'b1;
      default:                           func_ok = 1'b0;
    endcase
  end

  // add/sub wrap silently, identical to addu/subu
  always_comb begin
    alu_res = 32'd0;
    case (func_q)
      F_ADD, F_ADDU: alu_res = a_q + b_q;
      F_SUB, F_SUBU: alu_res = a_q - b_q;
      F_AND:         alu_res = a_q & b_q;
      F_OR:          alu_res = a_q | b_q;
      F_NOR:         alu_res = ~(a_q | b_q);
      F_SLL:         alu_res = b_q << shamt_q;
      F_SRL:         alu_res = b_q >> shamt_q;
      F_SLT:         alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
      F_SLTU:        alu_res = {31'd0, a_q < b_q};
      default:       alu_res = 32'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    a_d       = a_q;
    b_d       = b_q;
    shamt_d   = shamt_q;
    rd_d      = rd_q;
    func_d    = func_q;
    ill_d     = ill_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_q[instr_q[25:21]];
        b_d     = rf_q[instr_q[20:16]];
        shamt_d = instr_q[10:6];
        rd_d    = instr_q[15:11];
        func_d  = instr_q[5:0];
        ill_d   = (instr_q[31:26] != 6'd0) || !func_ok;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        // wb_rd/wb_data only move for legal instructions so they hold otherwise
        if (!ill_q) begin
          wb_rd_d   = rd_q;
          wb_data_d = alu_res;
        end
        state_d = S_WB;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // r0 is never written, so its reset value of 0 is permanent
  assign rf_we = (state_q == S_WB) && !ill_q && (wb_rd_q != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      instr_q   <= 32'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      shamt_q   <= 5'd0;
      rd_q      <= 5'd0;
      func_q    <= 6'd0;
      ill_q     <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'(i);
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      shamt_q   <= shamt_d;
      rd_q      <= rd_d;
      func_q    <= func_d;
      ill_q     <= ill_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      if (rf_we) rf_q[wb_rd_q] <= wb_data_q;
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign wb_valid    = (state_q == S_WB) && !ill_q;
  assign illegal     = (state_q == S_WB) && ill_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  // plain array read: a read in the write cycle returns the pre-write value
  assign dbg_data    = (dbg_addr == 5'd0) ? 32'd0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_mips32_rtype_sequencer.sv
module tb_mips32_rtype_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready, busy, wb_valid, illegal;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  mips32_rtype_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .busy(busy), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model_rf [32];
  logic [4:0]  last_rd;
  logic [31:0] last_data;

  typedef struct {
    logic [31:0] ins;
    logic        legal;
    logic [4:0]  rd;
    logic [31:0] data;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic ref_legal(input logic [31:0] ins);
    return (ins[31:26] == 6'd0) &&
           (ins[5:0] inside {6'h00, 6'h02, 6'h20, 6'h21, 6'h22, 6'h23,
                             6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B});
  endfunction

  function automatic logic [31:0] ref_alu(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      6'h20, 6'h21: return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      6'h22, 6'h23: return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
      6'h24: return a & b;
      6'h25: return a | b;
      6'h27: return ~(a | b);
      6'h00: return 32'(longint'(b) * (longint'(1) << sh));
      6'h02: return 32'(longint'(b) / (longint'(1) << sh));
      6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
      6'h2B: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'(i);
    last_rd = 5'd0;
    last_data = 32'd0;
  endtask

  task automatic check_rf(input string nm);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk(nm, dbg_data, model_rf[i]);
    end
    @(negedge clk);
  endtask

  // Offers one instruction from IDLE and checks every cycle until it retires.
  task automatic run_instr(input logic [31:0] ins, input logic legal,
                           input logic [4:0] rd, input logic [31:0] data);
    int w;
    logic [4:0]  erd;
    logic [31:0] edata;
    w = 0;
    while (!instr_ready && w < 10) begin @(negedge clk); w++; end
    chk("ready_before_accept", 32'(instr_ready), 32'd1);
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr = $urandom;
    chk("busy_decode", 32'(busy), 32'd1);
    chk("wbv_decode", 32'(wb_valid), 32'd0);
    @(negedge clk);
    chk("wbv_execute", 32'(wb_valid), 32'd0);
    chk("ill_execute", 32'(illegal), 32'd0);
    @(negedge clk);
    erd   = legal ? rd : last_rd;
    edata = legal ? data : last_data;
    chk("wb_valid", 32'(wb_valid), 32'(legal));
    chk("illegal", 32'(illegal), 32'(!legal));
    chk("wb_rd", 32'(wb_rd), 32'(erd));
    chk("wb_data", wb_data, edata);
    if (legal) begin
      dbg_addr = rd;
      #1;
      chk("dbg_old_in_wb", dbg_data, model_rf[rd]);
    end
    @(negedge clk);
    chk("wbv_after", 32'(wb_valid), 32'd0);
    chk("ill_after", 32'(illegal), 32'd0);
    chk("ready_after", 32'(instr_ready), 32'd1);
    chk("wb_data_hold", wb_data, edata);
    if (legal) begin
      if (rd != 5'd0) model_rf[rd] = data;
      dbg_addr = rd;
      #1;
      chk("dbg_after_wb", dbg_data, model_rf[rd]);
      last_rd = rd;
      last_data = data;
    end
  endtask

  initial begin
    logic [31:0] ins, res, d1;
    int c1, c2;
    logic [5:0] f;
    logic legal;
    dbg_addr = 5'd0;

    tbl[0] = '{32'h00853020, 1'b1, 5'd6,  32'd9};
    tbl[1] = '{32'h00E84822, 1'b1, 5'd9,  32'hFFFFFFFF};
    tbl[2] = '{32'h00097040, 1'b1, 5'd14, 32'hFFFFFFFE};
    tbl[3] = '{32'h0128502A, 1'b1, 5'd10, 32'd1};
    tbl[4] = '{32'h0128582B, 1'b1, 5'd11, 32'd0};
    tbl[5] = '{32'h8C850000, 1'b0, 5'd0,  32'd0};
    tbl[6] = '{32'h0085303F, 1'b0, 5'd0,  32'd0};
    tbl[7] = '{32'h00850020, 1'b1, 5'd0,  32'd9};

    // reset state
    do_reset();
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_ill", 32'(illegal), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    check_rf("rst_rf");

    // directed table
    for (int i = 0; i < 8; i++) begin
      run_instr(tbl[i].ins, tbl[i].legal, tbl[i].rd, tbl[i].data);
      @(negedge clk);
    end
    check_rf("tbl_rf");

    // back-to-back with instr_valid held: results 4 cycles apart
    do_reset();
    instr = 32'h00E84822;
    instr_valid = 1'b1;
    c1 = -1; c2 = -1; d1 = 32'd0;
    for (int i = 1; i < 16 && c2 < 0; i++) begin
      @(negedge clk);
      if (i == 1) instr = 32'h00097040;
      if (wb_valid) begin
        if (c1 < 0) begin c1 = i; d1 = wb_data; end
        else begin
          c2 = i;
          instr_valid = 1'b0;
          chk("b2b_second", wb_data, 32'hFFFFFFFE);
        end
      end
    end
    instr_valid = 1'b0;
    chk("b2b_first", d1, 32'hFFFFFFFF);
    chk("b2b_spacing", 32'(c2 - c1), 32'd4);
    chk("b2b_first_lat", 32'(c1), 32'd3);
    @(negedge clk);

    // reset during EXECUTE aborts the add
    do_reset();
    instr = 32'h00853020;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy_ex", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 32'(instr_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_wbv", 32'(wb_valid), 32'd0);
      @(negedge clk);
    end
    dbg_addr = 5'd6;
    #1;
    chk("abort_r6", dbg_data, 32'd6);
    @(negedge clk);

    // reset wins over a same-cycle accept
    rst = 1'b1;
    instr_valid = 1'b1;
    instr = 32'h00853020;
    @(negedge clk);
    rst = 1'b0;
    instr_valid = 1'b0;
    chk("rstprio_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("rstprio_no_wbv", 32'(wb_valid), 32'd0);
      @(negedge clk);
    end

    // randomized against the reference model
    do_reset();
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      case ($urandom_range(0, 10))
        0: f = 6'h00;  1: f = 6'h02;  2: f = 6'h20;  3: f = 6'h21;
        4: f = 6'h22;  5: f = 6'h23;  6: f = 6'h24;  7: f = 6'h25;
        8: f = 6'h27;  9: f = 6'h2A;  default: f = 6'h2B;
      endcase
      if ($urandom_range(0, 9) == 0) f = 6'($urandom_range(0, 63));
      ins = {6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), f};
      if ($urandom_range(0, 9) == 0) ins[31:26] = 6'($urandom_range(1, 63));
      legal = ref_legal(ins);
      res = ref_alu(ins[5:0], model_rf[ins[25:21]], model_rf[ins[20:16]], ins[10:6]);
      run_instr(ins, legal, ins[15:11], res);
      if (n % 50 == 49) check_rf("rand_rf");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
